// File: rtl/banked_main_mem.sv
// Four-bank, word-interleaved 16-bit main memory with per-bank busy timers and a fixed read latency.
// Optional: define BANKED_MEM_UNINIT_ERR_EN to track per-word valid bits and flag reads of unwritten words.
module banked_main_mem #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned BANK_CYCLES = 4,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int unsigned DW    = 16;
  localparam int unsigned NBANK = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WORDS = 2 ** ADDR_W;

  logic [DW-1:0]     r_mem [WORDS];
  logic [CNT_W-1:0]  r_cnt [NBANK];
  logic [CNT_W-1:0]  w_cnt_nxt [NBANK];
  logic [NBANK-1:0]  r_busy;
  logic [DW-1:0]     r_pd [RD_LAT-1];

  logic [1:0]        w_bank;
  logic [ADDR_W-1:0] w_word;
  logic              w_legal;
  logic              w_illegal;
  logic              w_acc;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [DW-1:0]     w_rd_word;
  logic              w_uninit_err;

  // Request decode: odd byte addresses and simultaneous rd/wr are rejected outright.
  assign w_bank    = addr[2:1];
  assign w_word    = addr[ADDR_W:1];
  assign w_legal   = (rd ^ wr) & ~addr[0];
  assign w_illegal = (rd | wr) & ~w_legal;
  assign w_acc     = w_legal & ~r_busy[w_bank];
  assign w_rd_acc  = w_acc & rd;
  assign w_wr_acc  = w_acc & wr & rst_n;
  assign stall     = w_legal & r_busy[w_bank];
  assign busy      = r_busy;

  // Per-bank countdown: load on accept, count down to zero otherwise.
  always_comb begin
    for (int k = 0; k < int'(NBANK); k++) begin
      w_cnt_nxt[k] = r_cnt[k];
      if (w_acc && (w_bank == 2'(k))) begin
        w_cnt_nxt[k] = CNT_W'(BANK_CYCLES);
      end else if (r_cnt[k] != '0) begin
        w_cnt_nxt[k] = r_cnt[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NBANK); k++) begin
        r_cnt[k] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int k = 0; k < int'(NBANK); k++) begin
        r_cnt[k]  <= w_cnt_nxt[k];
        r_busy[k] <= (w_cnt_nxt[k] != '0);
      end
    end
  end

  // Storage is never reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_word] <= data_in;
    end
  end

`ifdef BANKED_MEM_UNINIT_ERR_EN
  logic [WORDS-1:0]  r_vld;
  logic [RD_LAT-2:0] r_pu;

  assign w_rd_word    = r_vld[w_word] ? r_mem[w_word] : '0;
  assign w_uninit_err = r_pu[RD_LAT-2];

  // Valid bit per word plus an uninitialised-read flag travelling alongside the read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_pu  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_vld[w_word] <= 1'b1;
      end
      r_pu <= (RD_LAT-1)'({r_pu, w_rd_acc & ~r_vld[w_word]});
    end
  end
`else
  assign w_rd_word    = r_mem[w_word];
  assign w_uninit_err = 1'b0;
`endif

  // Read pipeline carries zero when no read is in flight, so data_out is zero outside the valid slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
        r_pd[i] <= '0;
      end
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      r_pd[0] <= w_rd_acc ? w_rd_word : '0;
      for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
        r_pd[i] <= r_pd[i-1];
      end
      data_out <= r_pd[RD_LAT-2];
      err      <= w_illegal | w_uninit_err;
    end
  end

endmodule

// File: tb/tb_banked_main_mem.sv
// Directed self-checking bench for banked_main_mem; cycle expectations are hand-derived.
module tb_banked_main_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  banked_main_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  // One clock cycle with the given request; returns mid-cycle with outputs settled.
  task automatic cyc(input logic i_rd, input logic i_wr, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    rd      = i_rd;
    wr      = i_wr;
    addr    = a;
    data_in = d;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
    idle(2);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_dout", data_out, 16'h0);
    chk("rst_stall", 16'(stall), 16'h0);
    rst_n = 1'b1;

    // Write then read back BEEF at 0x0008
    cyc(1'b0, 1'b1, 16'h0008, 16'hBEEF);
    chk("t1_wr_stall", 16'(stall), 16'h0);
    chk("t1_wr_busy", 16'(busy), 16'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("t1_busy_hold", 16'(busy), 16'h1);
    end
    cyc(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("t1_rd_stall", 16'(stall), 16'h0);
    chk("t1_rd_busy", 16'(busy), 16'h0);
    idle(1);
    chk("t1_dout_early", data_out, 16'h0);
    idle(1);
    chk("t1_dout", data_out, 16'hBEEF);
    chk("t1_err", 16'(err), 16'h0);
    idle(1);
    chk("t1_dout_late", data_out, 16'h0);
    idle(2);

    // Same-bank write stalls for BANK_CYCLES then is accepted
    cyc(1'b0, 1'b1, 16'h0010, 16'h1111);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 16'h0018, 16'h2222);
      chk("t2_stall", 16'(stall), 16'h1);
      chk("t2_busy", 16'(busy), 16'h1);
    end
    cyc(1'b0, 1'b1, 16'h0018, 16'h2222);
    chk("t2_accept_stall", 16'(stall), 16'h0);
    chk("t2_accept_busy", 16'(busy), 16'h0);
    idle(1);
    chk("t2_reload_busy", 16'(busy), 16'h1);
    idle(3);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(2);
    chk("t2_rd_0010", data_out, 16'h1111);
    idle(2);
    cyc(1'b1, 1'b0, 16'h0018, 16'h0000);
    idle(2);
    chk("t2_rd_0018", data_out, 16'h2222);
    idle(2);

    // Interleaved writes then back-to-back reads across all four banks
    cyc(1'b0, 1'b1, 16'h0000, 16'h0001);
    chk("t3_wr0_stall", 16'(stall), 16'h0);
    cyc(1'b0, 1'b1, 16'h0002, 16'h0002);
    chk("t3_wr1_stall", 16'(stall), 16'h0);
    cyc(1'b0, 1'b1, 16'h0004, 16'h0003);
    chk("t3_wr2_stall", 16'(stall), 16'h0);
    cyc(1'b0, 1'b1, 16'h0006, 16'h0004);
    chk("t3_wr3_stall", 16'(stall), 16'h0);
    idle(4);
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("t3_busy_r0", 16'(busy), 16'h0);
    cyc(1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("t3_busy_r1", 16'(busy), 16'h1);
    chk("t3_dout_r1", data_out, 16'h0);
    cyc(1'b1, 1'b0, 16'h0004, 16'h0000);
    chk("t3_busy_r2", 16'(busy), 16'h3);
    chk("t3_dout_1", data_out, 16'h1);
    cyc(1'b1, 1'b0, 16'h0006, 16'h0000);
    chk("t3_busy_r3", 16'(busy), 16'h7);
    chk("t3_dout_2", data_out, 16'h2);
    idle(1);
    chk("t3_busy_all", 16'(busy), 16'hF);
    chk("t3_dout_3", data_out, 16'h3);
    idle(1);
    chk("t3_dout_4", data_out, 16'h4);
    chk("t3_busy_drop0", 16'(busy), 16'hE);
    idle(1);
    chk("t3_dout_end", data_out, 16'h0);
    idle(4);

    // Illegal requests: one-cycle err, no stall, no side effects
    cyc(1'b1, 1'b1, 16'h0000, 16'hFFFF);
    chk("t4_rdwr_stall", 16'(stall), 16'h0);
    chk("t4_rdwr_err_now", 16'(err), 16'h0);
    idle(1);
    chk("t4_rdwr_err", 16'(err), 16'h1);
    chk("t4_rdwr_busy", 16'(busy), 16'h0);
    idle(1);
    chk("t4_rdwr_err_clr", 16'(err), 16'h0);
    cyc(1'b1, 1'b0, 16'h0003, 16'h0000);
    chk("t4_odd_stall", 16'(stall), 16'h0);
    idle(1);
    chk("t4_odd_err", 16'(err), 16'h1);
    chk("t4_odd_busy", 16'(busy), 16'h0);
    idle(1);
    chk("t4_odd_err_clr", 16'(err), 16'h0);
    chk("t4_odd_no_data", data_out, 16'h0);
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("t4_rd_stall", 16'(stall), 16'h0);
    cyc(1'b0, 1'b1, 16'h0001, 16'hFFFF);
    chk("t4_busybank_odd_stall", 16'(stall), 16'h0);
    chk("t4_busybank_busy", 16'(busy), 16'h1);
    cyc(1'b1, 1'b1, 16'h0000, 16'hFFFF);
    chk("t4_busybank_rdwr_stall", 16'(stall), 16'h0);
    chk("t4_busybank_err1", 16'(err), 16'h1);
    chk("t4_rd_data", data_out, 16'h1);
    idle(1);
    chk("t4_busybank_err2", 16'(err), 16'h1);
    idle(1);
    chk("t4_busybank_err_clr", 16'(err), 16'h0);
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("t4_reread_busy", 16'(busy), 16'h0);
    idle(2);
    chk("t4_array_intact", data_out, 16'h1);
    idle(2);

    // Reset drops an in-flight read
    cyc(1'b1, 1'b0, 16'h0020, 16'h0000);
    chk("t5_rd_stall", 16'(stall), 16'h0);
    idle(1);
    rst_n = 1'b0;
    chk("t5_busy_pre", 16'(busy), 16'h1);
    idle(1);
    rst_n = 1'b1;
    chk("t5_dout_rst", data_out, 16'h0);
    chk("t5_busy_rst", 16'(busy), 16'h0);
    chk("t5_err_rst", 16'(err), 16'h0);
    idle(1);
    chk("t5_dout_after", data_out, 16'h0);
    chk("t5_err_after", 16'(err), 16'h0);
    idle(1);
    chk("t5_dout_after2", data_out, 16'h0);
    chk("t5_err_after2", 16'(err), 16'h0);

    // Read of a never-written word, then of a word written before reset
    cyc(1'b1, 1'b0, 16'h0100, 16'h0000);
    chk("t6_rd_stall", 16'(stall), 16'h0);
    chk("t6_rd_busy", 16'(busy), 16'h0);
    idle(1);
    chk("t6_err_early", 16'(err), 16'h0);
    idle(1);
`ifdef BANKED_MEM_UNINIT_ERR_EN
    chk("t6_uninit_dout", data_out, 16'h0);
    chk("t6_uninit_err", 16'(err), 16'h1);
`else
    chk("t6_uninit_err", 16'(err), 16'h0);
`endif
    idle(1);
    chk("t6_err_late", 16'(err), 16'h0);
    idle(1);
    cyc(1'b1, 1'b0, 16'h0008, 16'h0000);
    idle(2);
`ifdef BANKED_MEM_UNINIT_ERR_EN
    chk("t6_postrst_dout", data_out, 16'h0);
    chk("t6_postrst_err", 16'(err), 16'h1);
`else
    chk("t6_postrst_dout", data_out, 16'hBEEF);
    chk("t6_postrst_err", 16'(err), 16'h0);
`endif
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
